port_scheduler: RTL and testbench

PORT_SCHEDULER -- requirements
Module: port_scheduler

---
 rtl/sched_pkg.sv | 27 ++
 rtl/port_scheduler_if.sv | 36 +++
 rtl/prio_first_set.sv | 22 ++
 rtl/port_scheduler.sv | 109 ++++++++++
 tb/tb_port_scheduler.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/sched_pkg.sv
// Shared constants, types and the per-queue weight function for the output-port scheduler.
// Queue 0 has the highest priority and the largest round-robin weight.
package sched_pkg;

    localparam int unsigned NUM_PRIO = 8;
    localparam int unsigned PRIO_W   = 3;
    localparam int unsigned CREDIT_W = 4;
    localparam int unsigned WDOG_W   = 10;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StWait
    } state_e;

    typedef logic [PRIO_W-1:0]   prio_t;
    typedef logic [CREDIT_W-1:0] credit_t;
    typedef logic [WDOG_W-1:0]   wdog_t;

    localparam wdog_t WDOG_MAX = '1;

    // W(q) = NUM_PRIO - q, so q0 gets 8 and q7 gets 1.
    function automatic credit_t weight(input prio_t q);
        return credit_t'(NUM_PRIO) - credit_t'(q);
    endfunction

endpackage

// File: rtl/port_scheduler_if.sv
// Handshake between the queue/datapath side (master) and the port scheduler (slave).
interface port_scheduler_if;
    import sched_pkg::*;

    logic                wrr_en;
    logic [NUM_PRIO-1:0] q_nonempty;
    logic                ready;
    logic                pkt_done;
    logic                grant_vld;
    prio_t               grant_prio;
    logic                busy;
    logic                timeout_err;

    modport master (
        output wrr_en,
        output q_nonempty,
        output ready,
        output pkt_done,
        input  grant_vld,
        input  grant_prio,
        input  busy,
        input  timeout_err
    );

    modport slave (
        input  wrr_en,
        input  q_nonempty,
        input  ready,
        input  pkt_done,
        output grant_vld,
        output grant_prio,
        output busy,
        output timeout_err
    );

endinterface

// File: rtl/prio_first_set.sv
// Lowest-set-bit encoder: idx is the lowest index with vec set, found flags any bit set.
module prio_first_set
    import sched_pkg::*;
(
    input  logic [NUM_PRIO-1:0] vec,
    output prio_t               idx,
    output logic                found
);

    always_comb begin
        idx = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = int'(NUM_PRIO) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = prio_t'(i);
            end
        end
    end

    assign found = |vec;

endmodule

// File: rtl/port_scheduler.sv
// Per-output-port packet scheduler: strict priority or weighted round robin selection,
// one-cycle grant pulse, then wait for end of packet under a watchdog.
module port_scheduler
    import sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    port_scheduler_if.slave  bus
);

    state_e  state_q, state_d;
    prio_t   prio_q, prio_d;
    wdog_t   wdog_q, wdog_d;
    logic    timeout_q, timeout_d;
    credit_t credit_q [NUM_PRIO];
    credit_t credit_d [NUM_PRIO];

    logic [NUM_PRIO-1:0] elig;
    prio_t               sp_idx, wrr_idx;
    logic                sp_found, wrr_found;

    always_comb begin
        for (int unsigned q = 0; q < NUM_PRIO; q++) begin
            elig[q] = bus.q_nonempty[q] && (credit_q[q] != '0);
        end
    end

    prio_first_set u_sp_sel (
        .vec   (bus.q_nonempty),
        .idx   (sp_idx),
        .found (sp_found)
    );

    prio_first_set u_wrr_sel (
        .vec   (elig),
        .idx   (wrr_idx),
        .found (wrr_found)
    );

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        wdog_d    = wdog_q;
        timeout_d = 1'b0;
        credit_d  = credit_q;

        case (state_q)
            StIdle: begin
                if (bus.ready && sp_found) begin
                    state_d = StGrant;
                    prio_d  = sp_idx;
                    if (bus.wrr_en) begin
                        if (wrr_found) begin
                            prio_d            = wrr_idx;
                            credit_d[wrr_idx] = credit_q[wrr_idx] - credit_t'(1);
                        end else begin
                            // Every backlogged queue is out of credit: start a new round.
                            for (int unsigned q = 0; q < NUM_PRIO; q++) begin
                                credit_d[q] = weight(prio_t'(q));
                            end
                            credit_d[sp_idx] = weight(sp_idx) - credit_t'(1);
                        end
                    end
                end
            end
            StGrant: begin
                state_d = StWait;
                wdog_d  = '0;
            end
            StWait: begin
                if (bus.pkt_done) begin
                    state_d = StIdle;
                end else if (wdog_q == WDOG_MAX) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + wdog_t'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            prio_q    <= '0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
            for (int unsigned q = 0; q < NUM_PRIO; q++) begin
                credit_q[q] <= weight(prio_t'(q));
            end
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
            credit_q  <= credit_d;
        end
    end

    assign bus.grant_vld   = (state_q == StGrant);
    assign bus.busy        = (state_q != StIdle);
    assign bus.grant_prio  = prio_q;
    assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_port_scheduler.sv
// Directed bench for port_scheduler: SP/WRR grant sequences, credit reload, input isolation
// during a packet, watchdog expiry and tie-break, and reset in the middle of a packet.
module tb_port_scheduler;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    port_scheduler_if bus ();

    port_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects a grant at the next edge, then ends the packet hold cycles into WAIT.
    task automatic serve(input logic [2:0] exp_prio, input int hold);
        tick();
        check_eq("grant_vld", 32'(bus.grant_vld), 32'd1);
        check_eq("grant_prio", 32'(bus.grant_prio), 32'(exp_prio));
        repeat (hold) tick();
        check_eq("busy_in_wait", 32'(bus.busy), 32'd1);
        bus.pkt_done = 1'b1;
        tick();
        bus.pkt_done = 1'b0;
        check_eq("idle_after_done", 32'(bus.busy), 32'd0);
    endtask

    task automatic run_vec(input logic [7:0] mask, input logic wrr, input logic [2:0] exp_prio,
                           input int n, input int hold);
        bus.q_nonempty = mask;
        bus.wrr_en     = wrr;
        for (int i = 0; i < n; i++) serve(exp_prio, hold);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        rst            = 1'b1;
        bus.wrr_en     = 1'b0;
        bus.q_nonempty = '0;
        bus.ready      = 1'b0;
        bus.pkt_done   = 1'b0;
        tick();
        tick();
        check_eq("rst_grant_vld", 32'(bus.grant_vld), 32'd0);
        check_eq("rst_grant_prio", 32'(bus.grant_prio), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_timeout", 32'(bus.timeout_err), 32'd0);

        rst       = 1'b0;
        bus.ready = 1'b1;

        // Strict priority: q2 wins over q4, pkt_done three cycles after each grant.
        run_vec(8'b0001_0100, 1'b0, 3'd2, 3, 3);

        // WRR from full credits: q2 (W=6) then q4 (W=4), then reload grants q2.
        // Six q2 grants also show that the SP phase left credits untouched.
        run_vec(8'b0001_0100, 1'b1, 3'd2, 6, 1);
        run_vec(8'b0001_0100, 1'b1, 3'd4, 4, 1);
        run_vec(8'b0001_0100, 1'b1, 3'd2, 1, 1);

        // WRR q0/q1 from reloaded credits: q0 x8, q1 x7, then reload grants q0.
        run_vec(8'b0000_0011, 1'b1, 3'd0, 8, 1);
        run_vec(8'b0000_0011, 1'b1, 3'd1, 7, 1);
        run_vec(8'b0000_0011, 1'b1, 3'd0, 1, 1);

        // Only q0: drain its 7 credits, the reload grant leaves credit[0] at 7,
        // so with q1 added q0 wins exactly 7 more times before q1.
        run_vec(8'b0000_0001, 1'b1, 3'd0, 8, 1);
        run_vec(8'b0000_0011, 1'b1, 3'd0, 7, 1);
        run_vec(8'b0000_0011, 1'b1, 3'd1, 1, 1);

        // SP grant; mode, queue and pkt_done changes during GRANT/WAIT must not disturb it.
        bus.wrr_en     = 1'b0;
        bus.q_nonempty = 8'b0000_0011;
        tick();
        check_eq("sp_grant_prio", 32'(bus.grant_prio), 32'd0);
        bus.pkt_done   = 1'b1;
        bus.wrr_en     = 1'b1;
        bus.q_nonempty = 8'h80;
        tick();
        bus.pkt_done   = 1'b0;
        check_eq("done_in_grant_ignored", 32'(bus.busy), 32'd1);
        check_eq("prio_held", 32'(bus.grant_prio), 32'd0);
        tick();
        check_eq("prio_held_wait", 32'(bus.grant_prio), 32'd0);
        bus.pkt_done = 1'b1;
        tick();
        bus.pkt_done = 1'b0;
        check_eq("idle_after_done2", 32'(bus.busy), 32'd0);
        // q7 has its full weight of 1; then q0 has no credit left (SP did not touch it).
        serve(3'd7, 1);
        run_vec(8'b0000_0011, 1'b1, 3'd1, 1, 1);

        // Not ready: no grant even with every queue backlogged.
        bus.ready      = 1'b0;
        bus.q_nonempty = 8'hff;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("no_grant_not_ready", 32'(bus.grant_vld), 32'd0);
        end

        // Watchdog expiry: count reaches 1023 in the 1024th WAIT cycle, pulse follows with IDLE.
        bus.wrr_en     = 1'b0;
        bus.q_nonempty = 8'h01;
        bus.ready      = 1'b1;
        tick();
        check_eq("wd_grant", 32'(bus.grant_vld), 32'd1);
        bus.ready = 1'b0;
        tick();
        n = 0;
        while (!bus.timeout_err && n < 1100) begin
            tick();
            n++;
        end
        check_eq("wd_latency", 32'(n), 32'd1024);
        check_eq("wd_busy_at_pulse", 32'(bus.busy), 32'd0);
        tick();
        check_eq("wd_pulse_one_cycle", 32'(bus.timeout_err), 32'd0);
        check_eq("wd_busy_after", 32'(bus.busy), 32'd0);

        // pkt_done in the expiry cycle wins over the watchdog.
        bus.ready = 1'b1;
        tick();
        check_eq("tie_grant", 32'(bus.grant_vld), 32'd1);
        bus.ready = 1'b0;
        tick();
        repeat (1023) tick();
        check_eq("tie_no_early_timeout", 32'(bus.timeout_err), 32'd0);
        check_eq("tie_still_busy", 32'(bus.busy), 32'd1);
        bus.pkt_done = 1'b1;
        tick();
        bus.pkt_done = 1'b0;
        check_eq("tie_timeout_suppressed", 32'(bus.timeout_err), 32'd0);
        check_eq("tie_idle", 32'(bus.busy), 32'd0);
        tick();
        check_eq("tie_timeout_later", 32'(bus.timeout_err), 32'd0);

        // Reset mid-packet: q0 spends a credit, reset in WAIT restores all weights.
        bus.ready      = 1'b1;
        bus.wrr_en     = 1'b1;
        bus.q_nonempty = 8'h01;
        tick();
        check_eq("pre_rst_grant", 32'(bus.grant_prio), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check_eq("mid_rst_grant_vld", 32'(bus.grant_vld), 32'd0);
        check_eq("mid_rst_grant_prio", 32'(bus.grant_prio), 32'd0);
        check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
        check_eq("mid_rst_timeout", 32'(bus.timeout_err), 32'd0);
        rst = 1'b0;
        run_vec(8'b0000_0011, 1'b1, 3'd0, 8, 1);
        run_vec(8'b0000_0011, 1'b1, 3'd1, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
